mul_slice_seq: RTL and testbench

Multi-cycle sequencer for the M-extension multiply unit. It accepts one 32x32 multiply (MUL, MULH, MULHSU, MULHU) per transaction and converts the operands to sign-magnitude form. It splits each magnitude into three 11-bit slices and drives the 9 slice pairs, one per cycle, into the external unsigned 11x11 slice-product datapath. It accumulates the shifted slice products into a 64-bit register, applies the sign, and returns the selected 32-bit half to the execute stage.

---
 rtl/mul_slice_seq_if.sv | 40 ++++
 rtl/mul_slice_seq.sv | 218 +++++++++++++++++++++
 tb/tb_mul_slice_seq.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_slice_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_slice_seq_if
// Description : Request/response and slice-datapath signals of the
//               multi-cycle multiply sequencer, bundled with modports.
//               master : execute stage plus the slice-product datapath
//               slave  : the sequencer itself
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_slice_seq_if #(
    parameter int SLICE_W = 11
);
    // Request / response
    logic               start;
    logic               rdy;
    logic [1:0]         funct;
    logic [31:0]        rs1;
    logic [31:0]        rs2;
    logic               flush;
    logic               busy;
    logic               done;
    logic [31:0]        result;

    // Slice-product datapath
    logic               dp_en;
    logic [SLICE_W-1:0] dp_a;
    logic [SLICE_W-1:0] dp_b;
    logic [63:0]        dp_prod;

    modport master (
        output start, funct, rs1, rs2, flush, dp_prod,
        input  rdy, busy, done, result, dp_en, dp_a, dp_b
    );

    modport slave (
        input  start, funct, rs1, rs2, flush, dp_prod,
        output rdy, busy, done, result, dp_en, dp_a, dp_b
    );
endinterface
`default_nettype wire

// File: rtl/mul_slice_seq.sv
`default_nettype none
// ============================================================================
// Module      : mul_slice_seq
// Description : Multi-cycle sequencer for the M-extension multiply. Converts
//               the operands to sign-magnitude, walks the 3x3 grid of 11-bit
//               magnitude slices through an external unsigned slice
//               multiplier, accumulates the shifted partial products, applies
//               the sign and returns the selected 32-bit half.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_slice_seq #(
    parameter int SLICE_W   = 11,   // only 11 is supported (3 slices = 33 bits)
    parameter bit EARLY_OUT = 1'b0  // zero operand finishes without the full walk
) (
    input  wire logic      clk,
    input  wire logic      rst,
    mul_slice_seq_if.slave bus
);

    // ------------------------------------------------------------------------
    // Encodings and constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [1:0] c_FN_MUL    = 2'b00;
    localparam logic [1:0] c_FN_MULH   = 2'b01;
    localparam logic [1:0] c_FN_MULHSU = 2'b10;

    localparam logic [3:0] c_LAST_K = 4'd8;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [3:0]  r_k;
    logic [31:0] r_mag_a;
    logic [31:0] r_mag_b;
    logic        r_neg;
    logic [1:0]  r_funct;
    logic [63:0] r_acc;
    logic [31:0] r_result;

    // ------------------------------------------------------------------------
    // Operand conversion at accept time
    // ------------------------------------------------------------------------
    logic        w_signed_a;
    logic        w_signed_b;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a_in;
    logic [31:0] w_mag_b_in;
    logic        w_accept;

    // MUL is handled as unsigned: its low half does not depend on signedness.
    assign w_signed_a = (bus.funct == c_FN_MULH) || (bus.funct == c_FN_MULHSU);
    assign w_signed_b = (bus.funct == c_FN_MULH);
    assign w_neg_a    = w_signed_a & bus.rs1[31];
    assign w_neg_b    = w_signed_b & bus.rs2[31];
    // -2^31 maps to 0x80000000, which is still a valid unsigned magnitude.
    assign w_mag_a_in = w_neg_a ? (~bus.rs1 + 32'd1) : bus.rs1;
    assign w_mag_b_in = w_neg_b ? (~bus.rs2 + 32'd1) : bus.rs2;
    assign w_accept   = (r_state == c_IDLE) && bus.start && !bus.flush;

    // ------------------------------------------------------------------------
    // Slice walk: k = 3*i + j, i selects the rs1 slice, j the rs2 slice
    // ------------------------------------------------------------------------
    logic [1:0]         w_i;
    logic [1:0]         w_j;
    logic [2:0]         w_ij;
    logic [5:0]         w_shift;
    logic [SLICE_W-1:0] w_slice_a;
    logic [SLICE_W-1:0] w_slice_b;
    logic [63:0]        w_term;
    logic [63:0]        w_signed_p;
    logic               w_zero_op;
    logic               w_unused_prod;

    function automatic logic [SLICE_W-1:0] f_slice(input logic [31:0] mag,
                                                   input logic [1:0]  idx);
        case (idx)
            2'd0:    f_slice = mag[SLICE_W-1:0];
            2'd1:    f_slice = mag[2*SLICE_W-1:SLICE_W];
            default: f_slice = {1'b0, mag[31:2*SLICE_W]};
        endcase
    endfunction

    // Map the step counter onto the (i, j) slice pair for this cycle.
    always_comb begin
        w_i = 2'd0;
        w_j = 2'd0;
        case (r_k)
            4'd0: begin w_i = 2'd0; w_j = 2'd0; end
            4'd1: begin w_i = 2'd0; w_j = 2'd1; end
            4'd2: begin w_i = 2'd0; w_j = 2'd2; end
            4'd3: begin w_i = 2'd1; w_j = 2'd0; end
            4'd4: begin w_i = 2'd1; w_j = 2'd1; end
            4'd5: begin w_i = 2'd1; w_j = 2'd2; end
            4'd6: begin w_i = 2'd2; w_j = 2'd0; end
            4'd7: begin w_i = 2'd2; w_j = 2'd1; end
            4'd8: begin w_i = 2'd2; w_j = 2'd2; end
            default: begin w_i = 2'd0; w_j = 2'd0; end
        endcase
    end

    assign w_slice_a = f_slice(r_mag_a, w_i);
    assign w_slice_b = f_slice(r_mag_b, w_j);
    assign w_ij      = {1'b0, w_i} + {1'b0, w_j};
    assign w_shift   = 6'(w_ij) * 6'(SLICE_W);
    // Top slices are 10 bits wide, so the largest term stays below 2^64.
    assign w_term    = 64'(bus.dp_prod[2*SLICE_W-1:0]) << w_shift;
    assign w_zero_op = (r_mag_a == 32'd0) || (r_mag_b == 32'd0);
    assign w_signed_p = r_neg ? (~r_acc + 64'd1) : r_acc;

    // Upper product bits are never produced by an 11x11 multiplier.
    assign w_unused_prod = ^bus.dp_prod[63:2*SLICE_W];

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // Advance the sequencer state; reset overrides flush and everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    // Flush returns to IDLE from anywhere and beats START in IDLE.
    always_comb begin
        w_next_state = r_state;
        if (bus.flush) begin
            w_next_state = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        w_next_state = c_CALC;
                    end
                end
                c_CALC: begin
                    // Zero detection looks at the registered magnitudes in the
                    // first walk cycle, so a skipped operation still spends one
                    // cycle in CALC and finishes two edges after accept.
                    if (EARLY_OUT && (r_k == 4'd0) && w_zero_op) begin
                        w_next_state = c_FIX;
                    end else if (r_k == c_LAST_K) begin
                        w_next_state = c_FIX;
                    end
                end
                c_FIX:   w_next_state = c_DONE;
                c_DONE:  w_next_state = c_IDLE;
                default: w_next_state = c_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    // Decode handshake and datapath drive from the current state.
    always_comb begin
        bus.rdy    = (r_state == c_IDLE);
        bus.busy   = (r_state != c_IDLE);
        bus.done   = (r_state == c_DONE);
        bus.dp_en  = (r_state == c_CALC);
        bus.dp_a   = '0;
        bus.dp_b   = '0;
        bus.result = r_result;
        if (r_state == c_CALC) begin
            bus.dp_a = w_slice_a;
            bus.dp_b = w_slice_b;
        end
    end

    // ------------------------------------------------------------------------
    // Operand latch, accumulator, step counter and result register
    // ------------------------------------------------------------------------
    // Capture operands on accept, accumulate during CALC, commit in FIX.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k      <= 4'd0;
            r_mag_a  <= 32'd0;
            r_mag_b  <= 32'd0;
            r_neg    <= 1'b0;
            r_funct  <= c_FN_MUL;
            r_acc    <= 64'd0;
            r_result <= 32'd0;
        end else begin
            if (w_accept) begin
                r_k     <= 4'd0;
                r_mag_a <= w_mag_a_in;
                r_mag_b <= w_mag_b_in;
                r_neg   <= w_neg_a ^ w_neg_b;
                r_funct <= bus.funct;
                r_acc   <= 64'd0;
            end else if ((r_state == c_CALC) && !bus.flush) begin
                r_acc <= r_acc + w_term;
                r_k   <= r_k + 4'd1;
            end

            // A flushed operation never reaches the result register.
            if ((r_state == c_FIX) && !bus.flush) begin
                r_result <= (r_funct == c_FN_MUL) ? w_signed_p[31:0]
                                                  : w_signed_p[63:32];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_slice_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_slice_seq
// Description : Scoreboard bench for mul_slice_seq. Two instances: one with
//               the full nine-step walk, one with the zero-operand early out.
//               The slice-product datapath is an 11x11 multiply in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_slice_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul_slice_seq_if #(.SLICE_W(11)) if0 ();
    mul_slice_seq_if #(.SLICE_W(11)) if1 ();

    mul_slice_seq #(.SLICE_W(11), .EARLY_OUT(1'b0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    mul_slice_seq #(.SLICE_W(11), .EARLY_OUT(1'b1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    // External unsigned slice multiplier.
    assign if0.dp_prod = 64'(if0.dp_a) * 64'(if0.dp_b);
    assign if1.dp_prod = 64'(if1.dp_a) * 64'(if1.dp_b);

    localparam logic [1:0] MUL    = 2'b00;
    localparam logic [1:0] MULH   = 2'b01;
    localparam logic [1:0] MULHSU = 2'b10;
    localparam logic [1:0] MULHU  = 2'b11;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] res;
        int          acc_cyc;
        int          lat;
        string       name;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor for instance 0: result, latency, walk length, idle datapath.
    int en_cnt0 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (if0.dp_en) en_cnt0++;
            else check("dp_idle_zero0", {42'd0, if0.dp_a, if0.dp_b}, 64'd0);
            if (if0.done) begin
                if (q0.size() == 0) begin
                    check("unexpected_done0", 64'd1, 64'd0);
                end else begin
                    e = q0.pop_front();
                    check({e.name, "_result"}, {32'd0, if0.result}, {32'd0, e.res});
                    check({e.name, "_latency"}, 64'(cyc - e.acc_cyc), 64'(e.lat));
                    check({e.name, "_dp_en_cycles"}, 64'(en_cnt0), 64'd9);
                end
            end
            if (if0.rdy) en_cnt0 = 0;
        end
    end

    // Monitor for instance 1: result and latency.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && if1.done) begin
            if (q1.size() == 0) begin
                check("unexpected_done1", 64'd1, 64'd0);
            end else begin
                e = q1.pop_front();
                check({e.name, "_result"}, {32'd0, if1.result}, {32'd0, e.res});
                check({e.name, "_latency"}, 64'(cyc - e.acc_cyc), 64'(e.lat));
            end
        end
    end

    // Issue one request to instance 0; returns on the negedge after accept.
    task automatic issue0(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input bit want_done, input bit hold,
                          input string name);
        int t = 0;
        @(negedge clk);
        while (!if0.rdy && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!if0.rdy) begin
            check({name, "_rdy_timeout"}, 64'd0, 64'd1);
        end else begin
            if0.start = 1'b1;
            if0.funct = f;
            if0.rs1   = a;
            if0.rs2   = b;
            @(negedge clk);
            if (want_done) q0.push_back('{res, cyc, 10, name});
            if (!hold) if0.start = 1'b0;
        end
    endtask

    // Issue one request to instance 1 with its expected latency.
    task automatic issue1(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input int lat, input string name);
        int t = 0;
        @(negedge clk);
        while (!if1.rdy && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!if1.rdy) begin
            check({name, "_rdy_timeout"}, 64'd0, 64'd1);
        end else begin
            if1.start = 1'b1;
            if1.funct = f;
            if1.rs1   = a;
            if1.rs2   = b;
            @(negedge clk);
            q1.push_back('{res, cyc, lat, name});
            if1.start = 1'b0;
        end
    endtask

    // Wait for instance 0 to drain its scoreboard.
    task automatic drain0(input string name);
        int t = 0;
        while (q0.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (q0.size() != 0) check({name, "_done_timeout"}, 64'(q0.size()), 64'd0);
    endtask

    initial begin
        int t;
        if0.start = 1'b0; if0.flush = 1'b0; if0.funct = MUL; if0.rs1 = '0; if0.rs2 = '0;
        if1.start = 1'b0; if1.flush = 1'b0; if1.funct = MUL; if1.rs1 = '0; if1.rs2 = '0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_rdy",    {63'd0, if0.rdy},   64'd1);
        check("reset_busy",   {63'd0, if0.busy},  64'd0);
        check("reset_done",   {63'd0, if0.done},  64'd0);
        check("reset_dp_en",  {63'd0, if0.dp_en}, 64'd0);
        check("reset_result", {32'd0, if0.result}, 64'd0);

        // Main function, hand-computed products.
        issue0(MUL,    32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 1, 0, "mul_m3x5");
        issue0(MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1, 0, "mulh_min_sq");
        issue0(MULH,   32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 1, 0, "mulh_m3x5");
        issue0(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 0, "mulhu_max_sq");
        issue0(MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1, 0, "mul_max_sq");
        issue0(MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1, 0, "mulhsu_m1x2");
        issue0(MULHU,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1, 0, "mulhu_max_x2");
        issue0(MUL,    32'h0000_07FF, 32'h0000_07FF, 32'h003F_F001, 1, 0, "mul_slice_edge");
        issue0(MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1, 0, "mulhu_2p32");
        drain0("main");

        // Flush at k=4: no DONE, back to IDLE, result keeps the last value.
        issue0(MUL, 32'h1234_5678, 32'h0000_0009, 32'h0, 0, 0, "flushed");
        repeat (4) @(negedge clk);
        if0.flush = 1'b1;
        @(negedge clk);
        if0.flush = 1'b0;
        check("flush_rdy",    {63'd0, if0.rdy},   64'd1);
        check("flush_busy",   {63'd0, if0.busy},  64'd0);
        check("flush_result", {32'd0, if0.result}, 64'h0000_0001);

        // START held through the whole operation is taken only once.
        issue0(MUL, 32'd7, 32'd6, 32'd42, 1, 1, "mul_7x6_held");
        t = 0;
        while (!if0.done && t < 40) begin
            @(negedge clk);
            t++;
        end
        if0.start = 1'b0;
        repeat (15) @(negedge clk);
        check("held_no_reaccept_busy", {63'd0, if0.busy}, 64'd0);
        check("held_queue_empty", 64'(q0.size()), 64'd0);

        // Early-out instance.
        issue1(MULH,  32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 2,  "eo_mulh_zero");
        issue1(MUL,   32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 10, "eo_mul_3x5");
        issue1(MULHU, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 2,  "eo_mulhu_zero");
        t = 0;
        while (q1.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (q1.size() != 0) check("eo_done_timeout", 64'(q1.size()), 64'd0);

        // Reset in the middle of CALC.
        issue0(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 0, 0, "rst_victim");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_result", {32'd0, if0.result}, 64'd0);
        check("midrst_done",   {63'd0, if0.done},   64'd0);
        check("midrst_dp_en",  {63'd0, if0.dp_en},  64'd0);
        check("midrst_dp_ab",  {42'd0, if0.dp_a, if0.dp_b}, 64'd0);
        check("midrst_busy",   {63'd0, if0.busy},   64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_rdy_after", {63'd0, if0.rdy}, 64'd1);
        repeat (15) @(negedge clk);
        check("midrst_result_after", {32'd0, if0.result}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
